// File: rtl/sobel_threshold.sv
// Gradient magnitude |Gx|+|Gy| against a per-frame threshold, 3-cycle binary edge map with
// aligned syncs, plus a per-frame edge-pixel counter that publishes its total on each vsync rise.
module sobel_threshold #(
  parameter int G_W   = 12,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [G_W-1:0]   in_gx,
  input  logic [G_W-1:0]   in_gy,
  input  logic             in_de,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic [G_W-1:0]   threshold,
  output logic [7:0]       out_bin,
  output logic             out_de,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid
);

  typedef enum logic {WAIT_FRAME, COUNT} state_t;

  // The most negative input has no positive counterpart, so it clamps to the max magnitude.
  function automatic logic [G_W-2:0] abs_sat(input logic [G_W-1:0] v);
    logic [G_W-1:0] neg;
    neg = ~v + 1'b1;
    if (!v[G_W-1])
      abs_sat = v[G_W-2:0];
    else if (v[G_W-2:0] == '0)
      abs_sat = '1;
    else
      abs_sat = neg[G_W-2:0];
  endfunction

  logic [G_W-2:0]   ax_s1, ay_s1;
  logic [G_W-1:0]   mag_s2;
  logic             de_s1, de_s2, hs_s1, hs_s2, vs_s1, vs_s2;
  logic             vs_prev;
  logic             load_pending;
  logic [G_W-1:0]   thr_shadow;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, edge_count_nxt;
  logic             count_valid_nxt;
  logic             vsync_rise, edge_pix;

  assign vsync_rise = out_vsync & ~vs_prev;
  assign edge_pix   = out_de && (out_bin == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      ax_s1        <= '0;
      ay_s1        <= '0;
      mag_s2       <= '0;
      de_s1        <= 1'b0;
      de_s2        <= 1'b0;
      hs_s1        <= 1'b0;
      hs_s2        <= 1'b0;
      vs_s1        <= 1'b0;
      vs_s2        <= 1'b0;
      out_bin      <= 8'h00;
      out_de       <= 1'b0;
      out_hsync    <= 1'b0;
      out_vsync    <= 1'b0;
      vs_prev      <= 1'b0;
      load_pending <= 1'b1;
      thr_shadow   <= '0;
      state        <= WAIT_FRAME;
      cnt          <= '0;
      edge_count   <= '0;
      count_valid  <= 1'b0;
    end else if (ce) begin
      ax_s1     <= abs_sat(in_gx);
      ay_s1     <= abs_sat(in_gy);
      de_s1     <= in_de;
      hs_s1     <= in_hsync;
      vs_s1     <= in_vsync;
      mag_s2    <= {1'b0, ax_s1} + {1'b0, ay_s1};
      de_s2     <= de_s1;
      hs_s2     <= hs_s1;
      vs_s2     <= vs_s1;
      out_bin   <= (de_s2 && (mag_s2 >= thr_shadow)) ? 8'hFF : 8'h00;
      out_de    <= de_s2;
      out_hsync <= hs_s2;
      out_vsync <= vs_s2;
      vs_prev   <= out_vsync;
      // Threshold port is only honoured right after reset and at frame boundaries.
      load_pending <= 1'b0;
      if (load_pending || vsync_rise)
        thr_shadow <= threshold;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      edge_count  <= edge_count_nxt;
      count_valid <= count_valid_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    edge_count_nxt  = edge_count;
    count_valid_nxt = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (vsync_rise) begin
          cnt_nxt   = '0;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (vsync_rise) begin
          edge_count_nxt  = cnt;
          count_valid_nxt = 1'b1;
          cnt_nxt         = edge_pix ? CNT_W'(1) : '0;
        end else if (edge_pix && (cnt != '1)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = WAIT_FRAME;
    endcase
  end

endmodule

// File: tb/tb_sobel_threshold.sv
// Directed bench for sobel_threshold: reset state, latency/alignment, saturated abs,
// threshold compare and per-frame shadowing, edge counting and clock-enable freeze.
module tb_sobel_threshold;

  logic        clk = 1'b0;
  logic        rst, ce;
  logic [11:0] in_gx, in_gy, threshold;
  logic        in_de, in_hsync, in_vsync;
  logic [7:0]  out_bin;
  logic        out_de, out_hsync, out_vsync;
  logic [19:0] edge_count;
  logic        count_valid;

  int checks = 0;
  int errors = 0;
  int cv_pulses = 0;

  logic [7:0] exp_bin [8];
  int         seq_gx  [8];
  int         seq_gy  [8];
  logic [7:0] hold_bin;
  logic       hold_de;

  sobel_threshold #(.G_W(12), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_gx(in_gx), .in_gy(in_gy), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .threshold(threshold),
    .out_bin(out_bin), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .edge_count(edge_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (count_valid === 1'b1) cv_pulses++;
  endtask

  task automatic set_pix(input int gx, input int gy, input logic de);
    in_gx = 12'(gx);
    in_gy = 12'(gy);
    in_de = de;
  endtask

  task automatic new_frame();
    set_pix(0, 0, 1'b0);
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset(input int thr);
    rst = 1'b1;
    threshold = 12'(thr);
    set_pix(0, 0, 1'b0);
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    ce = 1'b1; rst = 1'b1; threshold = 12'd1;
    set_pix(0, 0, 1'b0); in_hsync = 1'b0; in_vsync = 1'b0;
    exp_bin = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    seq_gx  = '{300, 0, -600, 499, 250, -2048, 100, 1};
    seq_gy  = '{-200, 0, 0, 0, 250, -2048, -399, -1};

    // 1. Reset state, zero gradient, sync alignment
    repeat (3) tick();
    check("rst_out_bin", out_bin, 8'h00);
    check("rst_out_de", out_de, 0);
    check("rst_out_syncs", {out_hsync, out_vsync}, 0);
    check("rst_edge_count", edge_count, 0);
    check("rst_count_valid", count_valid, 0);
    rst = 1'b0;
    repeat (4) tick();
    set_pix(0, 0, 1'b1); in_hsync = 1'b1;
    tick();
    in_hsync = 1'b0;
    tick();
    check("de_lat2", out_de, 0);
    check("hs_lat2", out_hsync, 0);
    tick();
    check("de_lat3", out_de, 1);
    check("hs_lat3", out_hsync, 1);
    check("zero_grad_bin", out_bin, 8'h00);
    tick();
    check("hs_pulse_end", out_hsync, 0);
    repeat (6) tick();
    check("zero_grad_bin_late", out_bin, 8'h00);
    set_pix(0, 0, 1'b0);
    repeat (3) tick();
    check("de_off", out_de, 0);
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
    tick();
    check("vs_lat2", out_vsync, 0);
    tick();
    check("vs_lat3", out_vsync, 1);
    tick();
    check("vs_pulse_end", out_vsync, 0);

    // 2. Saturated absolute value
    threshold = 12'd2047;
    new_frame();
    set_pix(-2048, 0, 1'b1);
    repeat (3) tick();
    check("sat_thr2047", out_bin, 8'hFF);
    threshold = 12'd2048;
    new_frame();
    set_pix(-2048, 0, 1'b1);
    repeat (3) tick();
    check("sat_thr2048", out_bin, 8'h00);

    // 3. Mixed signs, equality boundary and latency
    threshold = 12'd500;
    new_frame();
    set_pix(300, -200, 1'b1);
    tick();
    set_pix(0, 0, 1'b0);
    tick();
    check("mix500_lat2", out_bin, 8'h00);
    tick();
    check("mix500_lat3", out_bin, 8'hFF);
    tick();
    check("mix500_lat4", out_bin, 8'h00);
    threshold = 12'd501;
    new_frame();
    set_pix(300, -200, 1'b1);
    repeat (3) tick();
    check("mix501", out_bin, 8'h00);

    // 4. Edge counting: partial frame discarded, then 37 edges
    do_reset(100);
    set_pix(1000, 1000, 1'b1);
    repeat (5) tick();
    cv_pulses = 0;
    new_frame();
    check("partial_no_strobe", cv_pulses, 0);
    for (int i = 0; i < 37; i++) begin
      set_pix(1000, 1000, 1'b1);
      tick();
      if (i % 5 == 0) begin
        set_pix(1000, 1000, 1'b0);
        tick();
        set_pix(10, 10, 1'b1);
        tick();
      end
    end
    new_frame();
    check("frame_strobes", cv_pulses, 1);
    check("frame_count", edge_count, 37);
    repeat (3) tick();
    check("count_hold", edge_count, 37);
    check("strobe_once", cv_pulses, 1);

    // 5. Threshold change mid-frame takes effect at next vsync rise
    set_pix(1000, 1000, 1'b1);
    repeat (3) tick();
    check("thr100_edge", out_bin, 8'hFF);
    threshold = 12'd4000;
    repeat (5) tick();
    check("thr_shadow_hold", out_bin, 8'hFF);
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
    repeat (5) tick();
    check("thr4000_after_vs", out_bin, 8'h00);

    // 6. Reference run, then same run with a 5-cycle ce=0 freeze
    threshold = 12'd500;
    new_frame();
    for (int t = 0; t < 11; t++) begin
      if (t < 8) set_pix(seq_gx[t], seq_gy[t], 1'b1);
      else set_pix(0, 0, 1'b0);
      tick();
      if (t >= 2 && t < 10) begin
        check($sformatf("ref_bin%0d", t - 2), out_bin, exp_bin[t-2]);
        check($sformatf("ref_de%0d", t - 2), out_de, 1);
      end
    end
    for (int t = 0; t < 11; t++) begin
      if (t == 5) begin
        hold_bin = out_bin;
        hold_de  = out_de;
        ce = 1'b0;
        set_pix(2047, 2047, 1'b1);
        in_vsync = 1'b1;
        repeat (5) begin
          tick();
          check("freeze_bin", out_bin, hold_bin);
          check("freeze_de", out_de, hold_de);
        end
        ce = 1'b1;
        in_vsync = 1'b0;
      end
      if (t < 8) set_pix(seq_gx[t], seq_gy[t], 1'b1);
      else set_pix(0, 0, 1'b0);
      tick();
      if (t >= 2 && t < 10) begin
        check($sformatf("ce_bin%0d", t - 2), out_bin, exp_bin[t-2]);
        check($sformatf("ce_de%0d", t - 2), out_de, 1);
      end
    end
    check("ce_tail_de", out_de, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
